// File: rtl/input_buf_arbiter_if.sv
// Handshake bundle between the AXI wrapper, the conv engine and the
// input-buffer SRAM; the arbiter takes the slave side.
interface input_buf_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) ();
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [LEN_W-1:0]      bus_len;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic                  bus_gnt;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_rvalid;
  logic                  bus_done;
  logic                  eng_req;
  logic [ADDR_W-1:0]     eng_addr;
  logic [LEN_W-1:0]      eng_len;
  logic                  eng_gnt;
  logic [DATA_W-1:0]     eng_rdata;
  logic                  eng_rvalid;
  logic                  eng_done;
  logic                  sram_cs;
  logic [DATA_W/8-1:0]   sram_we;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_wdata;
  logic [DATA_W-1:0]     sram_rdata;

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_len,
    input  bus_wdata, bus_wstrb,
    output bus_gnt, bus_rdata, bus_rvalid, bus_done,
    input  eng_req, eng_addr, eng_len,
    output eng_gnt, eng_rdata, eng_rvalid, eng_done,
    output sram_cs, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output bus_req, bus_we, bus_addr, bus_len,
    output bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rdata, bus_rvalid, bus_done,
    output eng_req, eng_addr, eng_len,
    input  eng_gnt, eng_rdata, eng_rvalid, eng_done,
    input  sram_cs, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/input_buf_arbiter.sv
// Bus/engine burst arbiter for the single-port input-buffer SRAM.
// INBUF_ENG_PRIORITY_EN: engine wins every tie instead of round-robin.
module input_buf_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input_buf_arbiter_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_ENG
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_we;
  logic                r_bus_rvalid;
  logic                r_eng_rvalid;
  logic                r_bus_done;
  logic                r_eng_done;
`ifndef INBUF_ENG_PRIORITY_EN
  logic                r_last_eng;
`endif

  logic                w_bus_acc;
  logic                w_eng_acc;
  logic                w_acc;
  logic                w_wr;
  logic                w_last;
  logic                w_pick_bus;
  logic                w_pick_eng;
  logic                w_rv;
  logic [DATA_W-1:0]   w_rdata;

  always_comb begin
    w_bus_acc = (r_state == S_BUS) && io.bus_req;
    w_eng_acc = (r_state == S_ENG) && io.eng_req;
    w_acc     = w_bus_acc || w_eng_acc;
    w_wr      = w_bus_acc && r_we;
    w_last    = (r_cnt == '0);
`ifdef INBUF_ENG_PRIORITY_EN
    w_pick_eng = io.eng_req;
`else
    // bus takes the tie unless it was the last one served
    w_pick_eng = io.eng_req && (!io.bus_req || !r_last_eng);
`endif
    w_pick_bus = io.bus_req && !w_pick_eng;
  end

  assign w_rv    = r_bus_rvalid || r_eng_rvalid;
  assign w_rdata = w_rv ? io.sram_rdata : '0;

  assign io.bus_gnt    = (r_state == S_BUS);
  assign io.eng_gnt    = (r_state == S_ENG);
  assign io.bus_rdata  = w_rdata;
  assign io.eng_rdata  = w_rdata;
  assign io.bus_rvalid = r_bus_rvalid;
  assign io.eng_rvalid = r_eng_rvalid;
  assign io.bus_done   = r_bus_done;
  assign io.eng_done   = r_eng_done;

  assign io.sram_cs    = w_acc;
  assign io.sram_we    = w_wr ? io.bus_wstrb : '0;
  assign io.sram_addr  = w_acc ? r_addr : '0;
  assign io.sram_wdata = w_wr ? io.bus_wdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_bus_rvalid <= 1'b0;
      r_eng_rvalid <= 1'b0;
      r_bus_done   <= 1'b0;
      r_eng_done   <= 1'b0;
`ifndef INBUF_ENG_PRIORITY_EN
      r_last_eng   <= 1'b1;
`endif
    end else begin
      r_bus_rvalid <= w_bus_acc && !r_we;
      r_eng_rvalid <= w_eng_acc;
      r_bus_done   <= w_bus_acc && w_last;
      r_eng_done   <= w_eng_acc && w_last;
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_pick_bus: begin
              r_state <= S_BUS;
              r_addr  <= io.bus_addr;
              r_cnt   <= io.bus_len;
              r_we    <= io.bus_we;
`ifndef INBUF_ENG_PRIORITY_EN
              r_last_eng <= 1'b0;
`endif
            end
            w_pick_eng: begin
              r_state <= S_ENG;
              r_addr  <= io.eng_addr;
              r_cnt   <= io.eng_len;
              r_we    <= 1'b0;
`ifndef INBUF_ENG_PRIORITY_EN
              r_last_eng <= 1'b1;
`endif
            end
            default: r_state <= S_IDLE;
          endcase
        end
        S_BUS, S_ENG: begin
          if (w_acc) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - LEN_W'(1);
            if (w_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buf_arbiter.sv
// Directed bench for input_buf_arbiter: vector table plus
// hand sequences for ties, wrap, stall and mid-burst reset.
module tb_input_buf_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_buf_arbiter_if u_if ();

  input_buf_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .io  (u_if)
  );

  logic [31:0] mem [0:16383];
  logic [31:0] r_mem_q;
  assign u_if.sram_rdata = r_mem_q;

  always @(posedge clk) begin
    if (u_if.sram_cs) begin
      if (u_if.sram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (u_if.sram_we[b])
            mem[u_if.sram_addr][8*b +: 8] <= u_if.sram_wdata[8*b +: 8];
      end else begin
        r_mem_q <= mem[u_if.sram_addr];
      end
    end
  end

  // ctl = {bgnt,egnt,cs,we[3:0],bdone,edone,brv,erv}
  typedef struct {
    logic        breq;
    logic        bwe;
    logic [13:0] baddr;
    logic [3:0]  blen;
    logic [31:0] bwd;
    logic        ereq;
    logic [13:0] eaddr;
    logic [3:0]  elen;
    logic [10:0] ctl;
    logic [13:0] sa;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [10];
  int   n_pass = 0;
  int   n_chk  = 0;

  function automatic logic [10:0] act();
    return {u_if.bus_gnt, u_if.eng_gnt, u_if.sram_cs, u_if.sram_we,
            u_if.bus_done, u_if.eng_done,
            u_if.bus_rvalid, u_if.eng_rvalid};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic drv(logic breq, logic bwe, logic [13:0] baddr,
                     logic [3:0] blen, logic [31:0] bwd, logic ereq,
                     logic [13:0] eaddr, logic [3:0] elen);
    @(negedge clk);
    u_if.bus_req   = breq;
    u_if.bus_we    = bwe;
    u_if.bus_addr  = baddr;
    u_if.bus_len   = blen;
    u_if.bus_wdata = bwd;
    u_if.bus_wstrb = 4'hF;
    u_if.eng_req   = ereq;
    u_if.eng_addr  = eaddr;
    u_if.eng_len   = elen;
    #1;
  endtask

  function automatic vec_t mk(logic breq, logic bwe, logic [13:0] baddr,
                              logic [3:0] blen, logic [31:0] bwd,
                              logic ereq, logic [13:0] eaddr,
                              logic [3:0] elen, logic [10:0] ctl,
                              logic [13:0] sa, logic [31:0] rd);
    vec_t v;
    v.breq = breq; v.bwe = bwe; v.baddr = baddr; v.blen = blen;
    v.bwd = bwd; v.ereq = ereq; v.eaddr = eaddr; v.elen = elen;
    v.ctl = ctl; v.sa = sa; v.rd = rd;
    return v;
  endfunction

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [1:0] tie_exp [6];
  string      nm;

  initial begin
    rst = 1'b0;
    u_if.bus_req = 0; u_if.bus_we = 0; u_if.bus_addr = 0;
    u_if.bus_len = 0; u_if.bus_wdata = 0; u_if.bus_wstrb = 0;
    u_if.eng_req = 0; u_if.eng_addr = 0; u_if.eng_len = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 32'(act()), 32'h0);
    chk("reset_addr", 32'(u_if.sram_addr), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // write 0x10..0x13 then engine reads two of them back;
    // addr/len wiggle mid-burst must be ignored
    vt[0] = mk(1,1,14'h10,4'd3,32'hA0, 0,14'h0,4'd0,
               11'b0_0_0_0000_0_0_0_0, 14'h0, 32'h0);
    vt[1] = mk(1,1,14'h10,4'd3,32'hA0, 0,14'h0,4'd0,
               11'b1_0_1_1111_0_0_0_0, 14'h10, 32'h0);
    vt[2] = mk(1,1,14'h10,4'd3,32'hA1, 0,14'h0,4'd0,
               11'b1_0_1_1111_0_0_0_0, 14'h11, 32'h0);
    vt[3] = mk(1,1,14'h55,4'd0,32'hA2, 0,14'h0,4'd0,
               11'b1_0_1_1111_0_0_0_0, 14'h12, 32'h0);
    vt[4] = mk(1,0,14'h55,4'd0,32'hA3, 0,14'h0,4'd0,
               11'b1_0_1_1111_0_0_0_0, 14'h13, 32'h0);
    vt[5] = mk(0,0,14'h0,4'd0,32'h0, 1,14'h10,4'd1,
               11'b0_0_0_0000_1_0_0_0, 14'h0, 32'h0);
    vt[6] = mk(0,0,14'h0,4'd0,32'h0, 1,14'h10,4'd1,
               11'b0_1_1_0000_0_0_0_0, 14'h10, 32'h0);
    vt[7] = mk(0,0,14'h0,4'd0,32'h0, 1,14'h10,4'd1,
               11'b0_1_1_0000_0_0_0_1, 14'h11, 32'hA0);
    vt[8] = mk(0,0,14'h0,4'd0,32'h0, 0,14'h10,4'd1,
               11'b0_0_0_0000_0_1_0_1, 14'h0, 32'hA1);
    vt[9] = mk(0,0,14'h0,4'd0,32'h0, 0,14'h0,4'd0,
               11'b0_0_0_0000_0_0_0_0, 14'h0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      drv(vt[i].breq, vt[i].bwe, vt[i].baddr, vt[i].blen, vt[i].bwd,
          vt[i].ereq, vt[i].eaddr, vt[i].elen);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_ctl"}, 32'(act()), 32'(vt[i].ctl));
      if (vt[i].ctl[8])
        chk({nm, "_addr"}, 32'(u_if.sram_addr), 32'(vt[i].sa));
      if (vt[i].ctl[7:4] != 4'h0)
        chk({nm, "_wdata"}, u_if.sram_wdata, vt[i].bwd);
      if (vt[i].ctl[0])
        chk({nm, "_erdata"}, u_if.eng_rdata, vt[i].rd);
    end

    // tie from reset, both requesters keep asking
`ifdef INBUF_ENG_PRIORITY_EN
    tie_exp = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`else
    tie_exp = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`endif
    pulse_rst();
    for (int i = 0; i < 6; i++) begin
      drv(1,0,14'h20,4'd0,32'h0, 1,14'h30,4'd0);
      chk($sformatf("tie%0d_gnt", i),
          32'({u_if.bus_gnt, u_if.eng_gnt}), 32'(tie_exp[i]));
    end
    repeat (2) drv(0,0,14'h0,4'd0,32'h0, 0,14'h0,4'd0);

    // bus read crossing the top of the address space
    drv(1,0,14'h3FFF,4'd2,32'h0, 0,14'h0,4'd0);
    chk("wrap_idle", 32'(u_if.sram_cs), 32'h0);
    drv(1,0,14'h3FFF,4'd2,32'h0, 0,14'h0,4'd0);
    chk("wrap_a0", 32'({u_if.sram_cs, u_if.sram_addr}), 32'h7FFF);
    drv(1,0,14'h3FFF,4'd2,32'h0, 0,14'h0,4'd0);
    chk("wrap_a1", 32'({u_if.sram_cs, u_if.sram_addr}), 32'h4000);
    drv(1,0,14'h3FFF,4'd2,32'h0, 0,14'h0,4'd0);
    chk("wrap_a2", 32'({u_if.sram_cs, u_if.sram_addr}), 32'h4001);
    drv(0,0,14'h0,4'd0,32'h0, 0,14'h0,4'd0);
    chk("wrap_done", 32'({u_if.bus_done, u_if.bus_rvalid}), 32'h3);

    // engine read with a 2-cycle stall while the bus is waiting
    drv(0,0,14'h0,4'd0,32'h0, 1,14'h40,4'd3);
    drv(0,0,14'h0,4'd0,32'h0, 1,14'h40,4'd3);
    chk("stall_b0", 32'({u_if.eng_gnt, u_if.sram_cs, u_if.sram_addr}),
        32'hC040);
    drv(0,0,14'h0,4'd0,32'h0, 1,14'h40,4'd3);
    chk("stall_b1", 32'(u_if.sram_addr), 32'h41);
    for (int i = 0; i < 2; i++) begin
      drv(1,0,14'h50,4'd0,32'h0, 0,14'h40,4'd3);
      chk($sformatf("stall_hold%0d", i),
          32'({u_if.bus_gnt, u_if.eng_gnt, u_if.sram_cs}), 32'h2);
    end
    drv(1,0,14'h50,4'd0,32'h0, 1,14'h40,4'd3);
    chk("stall_b2", 32'({u_if.sram_cs, u_if.sram_addr}), 32'h4042);
    drv(1,0,14'h50,4'd0,32'h0, 1,14'h40,4'd3);
    chk("stall_b3", 32'({u_if.eng_done, u_if.sram_cs, u_if.sram_addr}),
        32'h4043);
    drv(1,0,14'h50,4'd0,32'h0, 0,14'h40,4'd3);
    chk("stall_done", 32'({u_if.eng_gnt, u_if.eng_done}), 32'h1);
    drv(1,0,14'h50,4'd0,32'h0, 0,14'h40,4'd3);
    chk("stall_bus_gnt", 32'(u_if.bus_gnt), 32'h1);
    drv(0,0,14'h0,4'd0,32'h0, 0,14'h0,4'd0);

    // reset asserted during beat 2 of a len=7 write
    drv(1,1,14'h100,4'd7,32'h11, 0,14'h0,4'd0);
    drv(1,1,14'h100,4'd7,32'h11, 0,14'h0,4'd0);
    drv(1,1,14'h100,4'd7,32'h12, 0,14'h0,4'd0);
    chk("rst_b1", 32'({u_if.sram_cs, u_if.sram_addr}), 32'h4101);
    rst = 1'b0;
    #1;
    chk("rst_now_ctl", 32'(act()), 32'h0);
    chk("rst_now_addr", 32'(u_if.sram_addr), 32'h0);
    drv(1,1,14'h100,4'd7,32'h13, 0,14'h0,4'd0);
    chk("rst_hold_ctl", 32'(act()), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    u_if.bus_addr = 14'h200;
    u_if.bus_len  = 4'd0;
    #1;
    chk("rst_rel_idle", 32'(act()), 32'h0);
    drv(1,1,14'h200,4'd0,32'h5A, 0,14'h0,4'd0);
    chk("rst_regnt", 32'({u_if.bus_gnt, u_if.bus_done, u_if.sram_addr}),
        32'h8200);
    drv(0,0,14'h0,4'd0,32'h0, 0,14'h0,4'd0);
    chk("rst_redone", 32'({u_if.bus_gnt, u_if.bus_done}), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
